// File: rtl/projectile_pool.sv
// projectile_pool: bullet slot manager for the shooter game.
// Allocates the lowest free slot on a rate-limited fire request, advances
// every live bullet once per frame_tick, retires bullets that leave the
// screen or are flagged by collision logic, and answers the VGA pixel query.
// Optional feature: define SPREAD_SHOT_EN to make each accepted shot a
// three-bullet burst (vx = -SPREAD_VX, 0, +SPREAD_VX) on consecutive cycles.
module projectile_pool #(
  parameter int          N_SLOTS   = 30,
  parameter int          POS_W     = 10,
  parameter int          VEL_W     = 4,
  parameter int          ARM_DELAY = 5000000,
  parameter int          COOLDOWN  = 5000000,
  parameter int          X_OFFSET  = 13,
  parameter int          Y_OFFSET  = 10,
  parameter int          BULLET_W  = 2,
  parameter int          BULLET_H  = 6,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter logic [23:0] COLOR     = 24'hFFFF00,
  parameter int          SPREAD_VX = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       frame_tick,
  input  logic                       fire,
  input  logic [POS_W-1:0]           ship_x,
  input  logic [POS_W-1:0]           ship_y,
  input  logic [VEL_W-1:0]           fire_vy,
  input  logic [POS_W-1:0]           x,
  input  logic [POS_W-1:0]           y,
  input  logic [N_SLOTS-1:0]         collided,
  output logic [N_SLOTS*2*POS_W-1:0] bullet_pos,
  output logic [N_SLOTS-1:0]         active,
  output logic [6:0]                 free_count,
  output logic                       fire_ack,
  output logic                       fire_drop,
  output logic [23:0]                rgb
);

  // ARMING lasts ARM_DELAY cycles; COOLDOWN lasts COOLDOWN-1 cycles so that
  // the READY cycle that follows makes accepted shots exactly COOLDOWN apart.
  localparam logic [31:0]       ARM_LAST  = 32'(ARM_DELAY - 1);
  localparam logic [31:0]       COOL_LAST = (COOLDOWN >= 2) ? 32'(COOLDOWN - 2) : 32'd0;
  localparam logic [POS_W-1:0]  X_OFF     = POS_W'(X_OFFSET);
  localparam logic [POS_W-1:0]  Y_OFF     = POS_W'(Y_OFFSET);
  localparam logic signed [POS_W:0] X_MAX = (POS_W+1)'(SCREEN_W - 1);
  localparam logic signed [POS_W:0] Y_MAX = (POS_W+1)'(SCREEN_H - 1);
  localparam logic [POS_W:0]    BW_LIM    = (POS_W+1)'(BULLET_W);
  localparam logic [POS_W:0]    BH_LIM    = (POS_W+1)'(BULLET_H);
`ifdef SPREAD_SHOT_EN
  localparam logic [VEL_W-1:0]  SPREAD_POS = VEL_W'(SPREAD_VX);
  localparam logic [VEL_W-1:0]  SPREAD_NEG = VEL_W'(-SPREAD_VX);
`endif

  typedef enum logic [1:0] {
    ST_ARMING   = 2'd0,
    ST_READY    = 2'd1,
    ST_COOLDOWN = 2'd2
`ifdef SPREAD_SHOT_EN
    , ST_SPREAD = 2'd3
`endif
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        count_reg, count_next;
  logic               ack_reg, ack_next;
  logic               drop_reg, drop_next;
  logic [6:0]         free_count_reg, free_count_next;
`ifdef SPREAD_SHOT_EN
  logic               burst_reg, burst_next;
`endif

  logic [N_SLOTS-1:0] active_reg, active_next;
  logic [N_SLOTS-1:0] free_mask, alloc_onehot, alloc_sel, hit_vec;
  logic               any_free, alloc_en;
  logic [VEL_W-1:0]   alloc_vx;
  logic [POS_W-1:0]   spawn_x, spawn_y;

  // Allocation looks only at registered occupancy; lowest set bit of the free mask wins.
  assign free_mask    = ~active_reg;
  assign alloc_onehot = free_mask & (~free_mask + N_SLOTS'(1));
  assign any_free     = |free_mask;
  assign alloc_sel    = alloc_en ? alloc_onehot : '0;
  assign spawn_x      = ship_x + X_OFF;
  assign spawn_y      = ship_y - Y_OFF;

  // Fire FSM: next state, counter, allocation request and pulse outputs.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ack_next   = 1'b0;
    drop_next  = 1'b0;
    alloc_en   = 1'b0;
    alloc_vx   = '0;
`ifdef SPREAD_SHOT_EN
    burst_next = burst_reg;
`endif
    if (!start) begin
      state_next = ST_ARMING;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_ARMING: begin
          if (count_reg == ARM_LAST) begin
            state_next = ST_READY;
            count_next = '0;
          end else begin
            count_next = count_reg + 32'd1;
          end
        end
        ST_READY: begin
          if (fire) begin
            if (any_free) begin
              alloc_en = 1'b1;
              ack_next = 1'b1;
`ifdef SPREAD_SHOT_EN
              alloc_vx   = SPREAD_NEG;
              burst_next = 1'b0;
              state_next = ST_SPREAD;
`else
              state_next = (COOLDOWN > 1) ? ST_COOLDOWN : ST_READY;
`endif
            end else begin
              drop_next = 1'b1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (count_reg == COOL_LAST) begin
            state_next = ST_READY;
            count_next = '0;
          end else begin
            count_next = count_reg + 32'd1;
          end
        end
`ifdef SPREAD_SHOT_EN
        ST_SPREAD: begin
          if (any_free) begin
            alloc_en = 1'b1;
            ack_next = 1'b1;
            alloc_vx = burst_reg ? SPREAD_POS : '0;
            if (burst_reg) begin
              state_next = (COOLDOWN > 1) ? ST_COOLDOWN : ST_READY;
            end else begin
              burst_next = 1'b1;
            end
          end else begin
            // Pool ran dry mid-burst: report once and abandon the rest.
            drop_next  = 1'b1;
            state_next = (COOLDOWN > 1) ? ST_COOLDOWN : ST_READY;
          end
        end
`endif
        default: begin
          state_next = ST_ARMING;
          count_next = '0;
        end
      endcase
    end
  end

  // Fire FSM state and registered status outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg      <= ST_ARMING;
      count_reg      <= '0;
      ack_reg        <= 1'b0;
      drop_reg       <= 1'b0;
      free_count_reg <= 7'(N_SLOTS);
`ifdef SPREAD_SHOT_EN
      burst_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      ack_reg        <= ack_next;
      drop_reg       <= drop_next;
      free_count_reg <= free_count_next;
`ifdef SPREAD_SHOT_EN
      burst_reg      <= burst_next;
`endif
    end
  end

  // Free slots after this edge, registered alongside the active mask.
  always_comb begin
    free_count_next = 7'(N_SLOTS);
    for (int i = 0; i < N_SLOTS; i++) begin
      free_count_next = free_count_next - {6'd0, active_next[i]};
    end
  end

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    logic                    act_reg, act_next;
    logic [POS_W-1:0]        x_reg, x_next, y_reg, y_next;
    logic [VEL_W-1:0]        vx_reg, vx_next, vy_reg, vy_next;
    logic signed [POS_W:0]   nx, ny;
    logic                    off_screen;
    logic [POS_W:0]          dx, dy;

    // Candidate position one frame ahead, in signed POS_W+1 arithmetic.
    assign nx = $signed({1'b0, x_reg}) + $signed({{(POS_W+1-VEL_W){vx_reg[VEL_W-1]}}, vx_reg});
    assign ny = $signed({1'b0, y_reg}) + $signed({{(POS_W+1-VEL_W){vy_reg[VEL_W-1]}}, vy_reg});
    assign off_screen = nx[POS_W] || (nx > X_MAX) || ny[POS_W] || (ny > Y_MAX);

    // Slot update priority: collision clear, then allocation, then motion.
    always_comb begin
      act_next = act_reg;
      x_next   = x_reg;
      y_next   = y_reg;
      vx_next  = vx_reg;
      vy_next  = vy_reg;
      if (collided[gi] && act_reg) begin
        act_next = 1'b0;
      end else if (alloc_sel[gi]) begin
        act_next = 1'b1;
        x_next   = spawn_x;
        y_next   = spawn_y;
        vx_next  = alloc_vx;
        vy_next  = fire_vy;
      end else if (frame_tick && act_reg) begin
        if (off_screen) begin
          act_next = 1'b0;
        end else begin
          x_next = nx[POS_W-1:0];
          y_next = ny[POS_W-1:0];
        end
      end
    end

    // Slot storage; coordinates reset to the all-ones sentinel.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        act_reg <= 1'b0;
        x_reg   <= '1;
        y_reg   <= '1;
        vx_reg  <= '0;
        vy_reg  <= '0;
      end else begin
        act_reg <= act_next;
        x_reg   <= x_next;
        y_reg   <= y_next;
        vx_reg  <= vx_next;
        vy_reg  <= vy_next;
      end
    end

    assign active_reg[gi]  = act_reg;
    assign active_next[gi] = act_next;
    // Inactive slots always present the sentinel so nothing can match them.
    assign bullet_pos[2*POS_W*gi +: 2*POS_W] = act_reg ? {y_reg, x_reg} : '1;

    // Pixel coverage test; offsets are only meaningful once x>=bx and y>=by.
    assign dx = {1'b0, x} - {1'b0, x_reg};
    assign dy = {1'b0, y} - {1'b0, y_reg};
    assign hit_vec[gi] = act_reg && (x >= x_reg) && (dx < BW_LIM)
                                 && (y >= y_reg) && (dy < BH_LIM);
  end

  assign active     = active_reg;
  assign free_count = free_count_reg;
  assign fire_ack   = ack_reg;
  assign fire_drop  = drop_reg;
  assign rgb        = (|hit_vec) ? COLOR : 24'h000000;

endmodule

// File: tb/tb_projectile_pool.sv
// tb_projectile_pool: directed scenario with a scoreboard of expected
// fire_ack / fire_drop events (cycle, slot, position) for projectile_pool.
module tb_projectile_pool;

  localparam int NS = 4;

  logic          clock = 1'b0;
  logic          resetn, start, frame_tick, fire;
  logic [9:0]    ship_x, ship_y, x, y;
  logic [3:0]    fire_vy;
  logic [NS-1:0] collided;
  logic [NS*20-1:0] bullet_pos;
  logic [NS-1:0] active;
  logic [6:0]    free_count;
  logic          fire_ack, fire_drop;
  logic [23:0]   rgb;

  projectile_pool #(
    .N_SLOTS(NS), .ARM_DELAY(4), .COOLDOWN(3)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .frame_tick(frame_tick),
    .fire(fire), .ship_x(ship_x), .ship_y(ship_y), .fire_vy(fire_vy),
    .x(x), .y(y), .collided(collided), .bullet_pos(bullet_pos),
    .active(active), .free_count(free_count), .fire_ack(fire_ack),
    .fire_drop(fire_drop), .rgb(rgb)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          slot;
    logic [19:0] pos;
  } ack_t;

  ack_t ack_q[$];
  int   drop_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   base, base2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] slot_pos(input int k);
    return bullet_pos[k*20 +: 20];
  endfunction

  // One clock edge, then score pulses against the expected-event queues.
  task automatic tick();
    bit   exp_ack, exp_drop;
    ack_t e;
    @(posedge clock);
    #1;
    cyc++;
    exp_ack = (ack_q.size() > 0) && (ack_q[0].cyc == cyc);
    chk($sformatf("fire_ack@%0d", cyc), {63'd0, fire_ack}, {63'd0, exp_ack});
    if (exp_ack) begin
      e = ack_q.pop_front();
      chk($sformatf("ack_pos slot%0d@%0d", e.slot, cyc), {44'd0, slot_pos(e.slot)}, {44'd0, e.pos});
    end
    exp_drop = (drop_q.size() > 0) && (drop_q[0] == cyc);
    chk($sformatf("fire_drop@%0d", cyc), {63'd0, fire_drop}, {63'd0, exp_drop});
    if (exp_drop) void'(drop_q.pop_front());
  endtask

  function automatic ack_t mk(input int c, input int s, input int py, input int px);
    ack_t a;
    a.cyc  = c;
    a.slot = s;
    a.pos  = {10'(py), 10'(px)};
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; frame_tick = 1'b0; fire = 1'b0;
    ship_x = 10'd100; ship_y = 10'd200; fire_vy = 4'hE;
    x = '0; y = '0; collided = '0;

    // Reset held for two edges.
    tick();
    tick();
    chk("reset_active", {60'd0, active}, 64'd0);
    chk("reset_free", {57'd0, free_count}, 64'd4);
    chk("reset_rgb", {40'd0, rgb}, 64'd0);
    for (int k = 0; k < NS; k++) chk($sformatf("reset_sentinel%0d", k), {44'd0, slot_pos(k)}, 64'hFFFFF);

    // Start with fire held: start first sampled at base+1, ARMING spans 4
    // cycles, first ack registered at base+5, then every 3 cycles.
    resetn = 1'b1; start = 1'b1; fire = 1'b1;
    base = cyc;
    ack_q.push_back(mk(base + 5,  0, 190, 113));
    ack_q.push_back(mk(base + 8,  1, 190, 113));
    ack_q.push_back(mk(base + 11, 2, 190, 113));
    ack_q.push_back(mk(base + 14, 3, 190, 113));
    drop_q.push_back(base + 17);
    drop_q.push_back(base + 18);
    drop_q.push_back(base + 19);
    while (cyc < base + 5) tick();
    chk("free_after_first", {57'd0, free_count}, 64'd3);

    // Render query against slot 0 at (113,190), sprite 2x6.
    x = 10'd113; y = 10'd190; #1;
    chk("rgb_hit_corner", {40'd0, rgb}, 64'hFFFF00);
    x = 10'd115; #1;
    chk("rgb_right_edge", {40'd0, rgb}, 64'd0);
    x = 10'd114; y = 10'd195; #1;
    chk("rgb_hit_last", {40'd0, rgb}, 64'hFFFF00);
    y = 10'd196; #1;
    chk("rgb_below", {40'd0, rgb}, 64'd0);
    x = 10'd112; y = 10'd190; #1;
    chk("rgb_left", {40'd0, rgb}, 64'd0);
    x = '0; y = '0;

    while (cyc < base + 18) tick();
    chk("full_active", {60'd0, active}, 64'hF);
    chk("full_free", {57'd0, free_count}, 64'd0);

    // Collision frees slot 1; same-cycle shot still sees a full pool.
    collided = 4'b0010; ship_x = 10'd200; ship_y = 10'd300;
    tick();
    chk("collide_active", {60'd0, active}, 64'hD);
    chk("collide_free", {57'd0, free_count}, 64'd1);
    chk("collide_sentinel", {44'd0, slot_pos(1)}, 64'hFFFFF);
    collided = '0;
    ack_q.push_back(mk(base + 20, 1, 290, 213));
    tick();
    chk("refill_active", {60'd0, active}, 64'hF);

    // start=0 mid-cooldown together with a frame_tick: bullets still move.
    fire = 1'b0; start = 1'b0; frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("move_slot0", {44'd0, slot_pos(0)}, {44'd0, 10'd188, 10'd113});
    chk("move_slot1", {44'd0, slot_pos(1)}, {44'd0, 10'd288, 10'd213});

    // Free slot 0, then restart: ack timing must follow ARMING, not cooldown.
    collided = 4'b0001;
    tick();
    collided = '0;
    chk("free_slot0", {57'd0, free_count}, 64'd1);
    start = 1'b1; fire = 1'b1; ship_x = 10'd100; ship_y = 10'd11;
    base2 = cyc;
    ack_q.push_back(mk(base2 + 5, 0, 1, 113));
    while (cyc < base2 + 5) tick();
    fire = 1'b0;

    // Slot 0 at y=1 with vy=-2 leaves the top on this frame_tick.
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("retire_active", {60'd0, active}, 64'hE);
    chk("retire_free", {57'd0, free_count}, 64'd1);
    chk("retire_sentinel", {44'd0, slot_pos(0)}, 64'hFFFFF);
    chk("retire_slot1", {44'd0, slot_pos(1)}, {44'd0, 10'd286, 10'd213});
    tick();

    // Allocation and frame_tick in the same cycle: spawn position unmoved.
    fire = 1'b1; frame_tick = 1'b1; ship_x = 10'd300; ship_y = 10'd100;
    ack_q.push_back(mk(base2 + 8, 0, 90, 313));
    tick();
    fire = 1'b0; frame_tick = 1'b0;
    chk("spawn_tick_slot1", {44'd0, slot_pos(1)}, {44'd0, 10'd284, 10'd213});
    chk("spawn_tick_free", {57'd0, free_count}, 64'd0);

    for (int i = 0; i < 4; i++) tick();
    chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    chk("drop_queue_drained", 64'(drop_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
